mesi_snoop_cache: RTL and testbench
===================================

// Module: mesi_snoop_cache
// PURPOSE
//  Parametrised direct-mapped L1 with per-line MESI state, CPU request/response handshake and snoop port.
//  One instance per processor on the shared snooping bus; an external arbiter grants the bus.
//  Adds victim write-back, BusUpgr, a shared-line sense and snoop data supply (flush).
//  State encoding: I=0, S=1, M=2, E=3.
// PARAMETERS
//  ADDR_W   5  word address width
//  DATA_W   8  data word width
//  INDEX_W  2  line index bits; LINES=2**INDEX_W, tag = ADDR_W-INDEX_W upper bits
// PORTS
//  clock          in   1       single clock, all logic on posedge
//  reset          in   1       synchronous, active-high
//  cpu_req_valid  in   1       CPU request valid
//  cpu_req_write  in   1       1=write, 0=read
//  cpu_req_addr   in   ADDR_W  request address
//  cpu_req_wdata  in   DATA_W  write data
//  cpu_req_ready  out  1       1 only in IDLE; accept = valid & ready
//  cpu_resp_valid out  1       one-cycle completion pulse
//  cpu_resp_rdata out  DATA_W  read data, valid with cpu_resp_valid
//  bus_req        out  1       bus request to arbiter, held until bus_gnt
//  bus_gnt        in   1       grant
//  bus_cmd        out  2       0 none, 1 BusRd, 2 BusRdX, 3 BusUpgr; one cycle, first granted cycle
//  bus_addr       out  ADDR_W  address of bus_cmd / write-back
//  bus_wb_valid   out  1       victim write-back valid; held until bus_wb_ack
//  bus_wb_ack     in   1       write-back accepted
//  bus_wb_data    out  DATA_W  victim data
//  bus_shared_in  in   1       another cache holds the line; sampled with mem_rvalid
//  mem_rvalid     in   1       fill data valid
//  mem_rdata      in   DATA_W  fill data
//  snoop_valid    in   1       snoop transaction from another master
//  snoop_cmd      in   2       same encoding as bus_cmd
//  snoop_addr     in   ADDR_W  snooped address
//  snoop_shared   out  1       registered: snooped line was S/E/M
//  snoop_flush    out  1       registered: snooped line was M; data on snoop_data
//  snoop_data     out  DATA_W  flushed line data
// BEHAVIOUR
//  Reset: all line states I (tags/data not cleared); FSM=IDLE; all outputs 0 except cpu_req_ready=1.
//  Reset mid-transaction aborts it: bus_req/bus_wb_valid drop next cycle, no response issued.
//  FSM: IDLE -> LOOKUP on accept (request latched). LOOKUP decides:
//   read hit (S/E/M): resp next cycle -> IDLE; state unchanged.
//   write hit M: write data; E: write, ->M silently; both resp next cycle.
//   write hit S: -> BUS (BusUpgr); on grant write data, ->M, resp next cycle, no mem wait.
//   miss, victim M: -> WB (bus_wb_valid, victim addr/data) until ack, then -> BUS.
//   miss, victim I/S/E: -> BUS directly (clean victim dropped).
//  BUS: bus_req=1; first cycle with bus_gnt issues BusRd (read) or BusRdX (write) -> FILL.
//  FILL: wait mem_rvalid; write tag; read: data=mem_rdata, state S if bus_shared_in else E;
//   write: data=cpu_req_wdata (whole word), state M. Resp next cycle -> IDLE.
//  Read hit latency: accept at T, cpu_resp_valid at T+2.
//  Snoop (any state, including mid-miss): tag match & state!=I:
//   BusRd: M->S with flush; E->S; S stays. BusRdX: M->I with flush; S/E->I. BusUpgr: S->I.
//   snoop_shared/flush/data registered, valid the cycle after snoop_valid; otherwise 0.
//  Collision: snoop same cycle as LOOKUP on same index -> snoop applied first, LOOKUP repeats
//   one cycle with updated state. Snoop during BUS on pending S line -> BusUpgr converts to BusRdX.
//  snoop_valid ignored while own bus_gnt=1 (own transaction not self-snooped).
// TESTING
//  Cold read 0x05, mem_rdata=0xA1, shared_in=0 -> resp 0xA1, line E; re-read -> resp at T+2, no bus_req.
//  Write 0x05 data 0x3C on E line -> no bus_cmd, line M; snoop BusRd 0x05 -> flush=1, data 0x3C, line S.
//  Write hit on S line -> bus_cmd=3 once after grant, line M; BusRd fill with shared_in=1 -> line S.
//  Miss 0x0D evicting M line 0x05 (INDEX_W=2) -> bus_wb_valid addr 0x05 until ack, then BusRd 0x0D.
//  Snoop BusRdX same cycle as LOOKUP on same index -> LOOKUP stalls 1 cycle, sees I, issues miss.
//  Assert reset during FILL -> next cycle FSM IDLE, ready=1, all lines I, no cpu_resp_valid.

Source files
------------

// File: rtl/mesi_snoop_cache.sv
// -----------------------------------------------------------------------------
// mesi_snoop_cache
// Direct-mapped L1 cache with per-line MESI state. It serves a CPU through a
// request/response handshake and takes part in a shared snooping bus: it
// issues BusRd/BusRdX/BusUpgr, writes back dirty victims, reacts to snooped
// transactions from other masters and supplies (flushes) Modified data.
// Line state encoding: I=0, S=1, M=2, E=3.
//
// Ports
//   clock_i, reset_i      single clock, synchronous active-high reset
//   cpu_req_*_i / _o      CPU request (valid/ready handshake, write, addr, wdata)
//   cpu_resp_*_o          one-cycle completion pulse with read data
//   bus_req_o/bus_gnt_i   bus request to the external arbiter and its grant
//   bus_cmd_o/bus_addr_o  command (0 none,1 BusRd,2 BusRdX,3 BusUpgr) on the
//                         first granted cycle, and the address of cmd/write-back
//   bus_wb_*              victim write-back (valid/data out, ack in)
//   bus_shared_in_i       another cache holds the line, sampled with mem_rvalid_i
//   mem_rvalid_i/rdata_i  fill data from memory
//   snoop_*_i             snooped transaction from another master
//   snoop_shared/flush/data_o  registered snoop reply, valid the cycle after
// -----------------------------------------------------------------------------
module mesi_snoop_cache #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 8,
   parameter int INDEX_W = 2
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              cpu_req_valid_i,
   input  logic              cpu_req_write_i,
   input  logic [ADDR_W-1:0] cpu_req_addr_i,
   input  logic [DATA_W-1:0] cpu_req_wdata_i,
   output logic              cpu_req_ready_o,
   output logic              cpu_resp_valid_o,
   output logic [DATA_W-1:0] cpu_resp_rdata_o,
   output logic              bus_req_o,
   input  logic              bus_gnt_i,
   output logic [1:0]        bus_cmd_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic              bus_wb_valid_o,
   input  logic              bus_wb_ack_i,
   output logic [DATA_W-1:0] bus_wb_data_o,
   input  logic              bus_shared_in_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              snoop_valid_i,
   input  logic [1:0]        snoop_cmd_i,
   input  logic [ADDR_W-1:0] snoop_addr_i,
   output logic              snoop_shared_o,
   output logic              snoop_flush_o,
   output logic [DATA_W-1:0] snoop_data_o
);
   localparam int LINES = 2 ** INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W;

   localparam logic [1:0] ST_I = 2'd0;
   localparam logic [1:0] ST_S = 2'd1;
   localparam logic [1:0] ST_M = 2'd2;
   localparam logic [1:0] ST_E = 2'd3;

   localparam logic [1:0] CMD_NONE = 2'd0;
   localparam logic [1:0] CMD_RD   = 2'd1;
   localparam logic [1:0] CMD_RDX  = 2'd2;
   localparam logic [1:0] CMD_UPGR = 2'd3;

   typedef enum logic [2:0] {F_IDLE, F_LOOKUP, F_WB, F_BUS, F_FILL} fsm_t;

   fsm_t              fsm_q;
   logic [1:0]        line_st_q   [LINES];
   logic [TAG_W-1:0]  line_tag_q  [LINES];
   logic [DATA_W-1:0] line_data_q [LINES];

   logic              req_write_q;
   logic [ADDR_W-1:0] req_addr_q;
   logic [DATA_W-1:0] req_wdata_q;
   logic [1:0]        pend_cmd_q;

   logic              ready_q;
   logic              resp_valid_q;
   logic [DATA_W-1:0] resp_rdata_q;
   logic              bus_req_q;
   logic [ADDR_W-1:0] bus_addr_q;
   logic              wb_valid_q;
   logic [DATA_W-1:0] wb_data_q;
   logic              snoop_shared_q;
   logic              snoop_flush_q;
   logic [DATA_W-1:0] snoop_data_q;

   // Request decode
   logic [INDEX_W-1:0] req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic [1:0]         lk_st;
   logic               lk_hit;
   logic               lk_collide;

   assign req_idx = req_addr_q[INDEX_W-1:0];
   assign req_tag = req_addr_q[ADDR_W-1:INDEX_W];
   assign lk_st   = line_st_q[req_idx];
   assign lk_hit  = (lk_st != ST_I) && (line_tag_q[req_idx] == req_tag);

   // Snoop decode; our own granted transaction is never snooped back
   logic [INDEX_W-1:0] snp_idx;
   logic [TAG_W-1:0]   snp_tag;
   logic               snp_act;
   logic               snp_hit;
   logic               snp_flush;
   logic [1:0]         snp_cur_st;
   logic [1:0]         snp_st_d;

   assign snp_idx    = snoop_addr_i[INDEX_W-1:0];
   assign snp_tag    = snoop_addr_i[ADDR_W-1:INDEX_W];
   assign snp_act    = snoop_valid_i && !bus_gnt_i && (snoop_cmd_i != CMD_NONE);
   assign snp_cur_st = line_st_q[snp_idx];
   assign snp_hit    = snp_act && (line_tag_q[snp_idx] == snp_tag) && (snp_cur_st != ST_I);
   assign snp_flush  = snp_hit && (snp_cur_st == ST_M) &&
                       ((snoop_cmd_i == CMD_RD) || (snoop_cmd_i == CMD_RDX));

   // A snoop on the line LOOKUP is examining wins; LOOKUP re-evaluates next cycle
   assign lk_collide = snp_act && (snp_idx == req_idx);

   always_comb begin
      snp_st_d = snp_cur_st;
      case (snoop_cmd_i)
         CMD_RD:   snp_st_d = ST_S;
         CMD_RDX:  snp_st_d = ST_I;
         CMD_UPGR: if (snp_cur_st == ST_S) snp_st_d = ST_I;
         default:  snp_st_d = snp_cur_st;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fsm_q          <= F_IDLE;
         req_write_q    <= 1'b0;
         req_addr_q     <= '0;
         req_wdata_q    <= '0;
         pend_cmd_q     <= CMD_NONE;
         ready_q        <= 1'b1;
         resp_valid_q   <= 1'b0;
         resp_rdata_q   <= '0;
         bus_req_q      <= 1'b0;
         bus_addr_q     <= '0;
         wb_valid_q     <= 1'b0;
         wb_data_q      <= '0;
         snoop_shared_q <= 1'b0;
         snoop_flush_q  <= 1'b0;
         snoop_data_q   <= '0;
         // Tags and data are left as-is; clearing the state makes them dead
         for (int i = 0; i < LINES; i++) line_st_q[i] <= ST_I;
      end else begin
         resp_valid_q   <= 1'b0;
         snoop_shared_q <= snp_hit;
         snoop_flush_q  <= snp_flush;
         snoop_data_q   <= snp_flush ? line_data_q[snp_idx] : '0;

         case (fsm_q)
            F_IDLE: begin
               if (cpu_req_valid_i && ready_q) begin
                  req_write_q <= cpu_req_write_i;
                  req_addr_q  <= cpu_req_addr_i;
                  req_wdata_q <= cpu_req_wdata_i;
                  ready_q     <= 1'b0;
                  fsm_q       <= F_LOOKUP;
               end
            end

            F_LOOKUP: begin
               if (!lk_collide) begin
                  if (lk_hit && !req_write_q) begin
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= line_data_q[req_idx];
                     ready_q      <= 1'b1;
                     fsm_q        <= F_IDLE;
                  end else if (lk_hit && (lk_st != ST_S)) begin
                     // E or M: exclusive ownership, write locally
                     line_data_q[req_idx] <= req_wdata_q;
                     line_st_q[req_idx]   <= ST_M;
                     resp_valid_q         <= 1'b1;
                     resp_rdata_q         <= req_wdata_q;
                     ready_q              <= 1'b1;
                     fsm_q                <= F_IDLE;
                  end else if (lk_hit) begin
                     pend_cmd_q <= CMD_UPGR;
                     bus_req_q  <= 1'b1;
                     bus_addr_q <= req_addr_q;
                     fsm_q      <= F_BUS;
                  end else if (lk_st == ST_M) begin
                     // Dirty victim must reach memory before the refill
                     pend_cmd_q <= req_write_q ? CMD_RDX : CMD_RD;
                     wb_valid_q <= 1'b1;
                     wb_data_q  <= line_data_q[req_idx];
                     bus_addr_q <= {line_tag_q[req_idx], req_idx};
                     fsm_q      <= F_WB;
                  end else begin
                     line_st_q[req_idx] <= ST_I;
                     pend_cmd_q <= req_write_q ? CMD_RDX : CMD_RD;
                     bus_req_q  <= 1'b1;
                     bus_addr_q <= req_addr_q;
                     fsm_q      <= F_BUS;
                  end
               end
            end

            F_WB: begin
               if (bus_wb_ack_i) begin
                  wb_valid_q         <= 1'b0;
                  line_st_q[req_idx] <= ST_I;
                  bus_req_q          <= 1'b1;
                  bus_addr_q         <= req_addr_q;
                  fsm_q              <= F_BUS;
               end
            end

            F_BUS: begin
               if (bus_gnt_i) begin
                  bus_req_q <= 1'b0;
                  if (pend_cmd_q == CMD_UPGR) begin
                     line_data_q[req_idx] <= req_wdata_q;
                     line_st_q[req_idx]   <= ST_M;
                     resp_valid_q         <= 1'b1;
                     resp_rdata_q         <= req_wdata_q;
                     ready_q              <= 1'b1;
                     fsm_q                <= F_IDLE;
                  end else begin
                     fsm_q <= F_FILL;
                  end
               end else if (snp_hit && (snp_idx == req_idx) && (snp_st_d == ST_I) &&
                            (pend_cmd_q == CMD_UPGR)) begin
                  // Our shared copy was taken away: the upgrade becomes a full miss
                  pend_cmd_q <= CMD_RDX;
               end
            end

            F_FILL: begin
               if (mem_rvalid_i) begin
                  line_tag_q[req_idx] <= req_tag;
                  if (req_write_q) begin
                     line_data_q[req_idx] <= req_wdata_q;
                     line_st_q[req_idx]   <= ST_M;
                     resp_rdata_q         <= req_wdata_q;
                  end else begin
                     line_data_q[req_idx] <= mem_rdata_i;
                     line_st_q[req_idx]   <= bus_shared_in_i ? ST_S : ST_E;
                     resp_rdata_q         <= mem_rdata_i;
                  end
                  resp_valid_q <= 1'b1;
                  ready_q      <= 1'b1;
                  fsm_q        <= F_IDLE;
               end
            end

            default: begin
               ready_q <= 1'b1;
               fsm_q   <= F_IDLE;
            end
         endcase

         if (snp_hit) line_st_q[snp_idx] <= snp_st_d;
      end
   end

   assign cpu_req_ready_o  = ready_q;
   assign cpu_resp_valid_o = resp_valid_q;
   assign cpu_resp_rdata_o = resp_rdata_q;
   assign bus_req_o        = bus_req_q;
   // Command is presented only in the cycle the grant is seen
   assign bus_cmd_o        = ((fsm_q == F_BUS) && bus_gnt_i) ? pend_cmd_q : CMD_NONE;
   assign bus_addr_o       = bus_addr_q;
   assign bus_wb_valid_o   = wb_valid_q;
   assign bus_wb_data_o    = wb_data_q;
   assign snoop_shared_o   = snoop_shared_q;
   assign snoop_flush_o    = snoop_flush_q;
   assign snoop_data_o     = snoop_data_q;

endmodule

// File: tb/tb_mesi_snoop_cache.sv
// -----------------------------------------------------------------------------
// tb_mesi_snoop_cache
// Directed MESI scenarios followed by a randomized mix of CPU operations and
// snoops. The bench plays arbiter, memory and other masters, and predicts
// every response from an address-level MESI model.
// -----------------------------------------------------------------------------
module tb_mesi_snoop_cache;
   localparam int I = 0, S = 1, M = 2, E = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cpu_req_valid = 1'b0, cpu_req_write = 1'b0;
   logic [4:0] cpu_req_addr = '0;
   logic [7:0] cpu_req_wdata = '0;
   logic       cpu_req_ready, cpu_resp_valid;
   logic [7:0] cpu_resp_rdata;
   logic       bus_req, bus_gnt = 1'b0;
   logic [1:0] bus_cmd;
   logic [4:0] bus_addr;
   logic       bus_wb_valid, bus_wb_ack = 1'b0;
   logic [7:0] bus_wb_data;
   logic       bus_shared_in = 1'b0, mem_rvalid = 1'b0;
   logic [7:0] mem_rdata = '0;
   logic       snoop_valid = 1'b0;
   logic [1:0] snoop_cmd = '0;
   logic [4:0] snoop_addr = '0;
   logic       snoop_shared, snoop_flush;
   logic [7:0] snoop_data;

   int checks = 0;
   int failures = 0;

   // Model: which address each index holds, its MESI state and data
   int         m_st   [4];
   logic [4:0] m_addr [4];
   logic [7:0] m_data [4];

   always #5 clk = ~clk;

   mesi_snoop_cache #(.ADDR_W(5), .DATA_W(8), .INDEX_W(2)) dut (
      .clock_i(clk), .reset_i(rst),
      .cpu_req_valid_i(cpu_req_valid), .cpu_req_write_i(cpu_req_write),
      .cpu_req_addr_i(cpu_req_addr), .cpu_req_wdata_i(cpu_req_wdata),
      .cpu_req_ready_o(cpu_req_ready), .cpu_resp_valid_o(cpu_resp_valid),
      .cpu_resp_rdata_o(cpu_resp_rdata),
      .bus_req_o(bus_req), .bus_gnt_i(bus_gnt), .bus_cmd_o(bus_cmd), .bus_addr_o(bus_addr),
      .bus_wb_valid_o(bus_wb_valid), .bus_wb_ack_i(bus_wb_ack), .bus_wb_data_o(bus_wb_data),
      .bus_shared_in_i(bus_shared_in), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .snoop_valid_i(snoop_valid), .snoop_cmd_i(snoop_cmd), .snoop_addr_i(snoop_addr),
      .snoop_shared_o(snoop_shared), .snoop_flush_o(snoop_flush), .snoop_data_o(snoop_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_lines(input string tag);
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s line_st[%0d]", tag, i), 32'(dut.line_st_q[i]), m_st[i]);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_st[i] = I;
   endtask

   // Effect of another master's transaction on our copy of address a
   task automatic model_snoop(input int cmd, input logic [4:0] a,
                              output bit sh, output bit fl, output logic [7:0] d);
      int  ix;
      bit  hit;
      ix  = int'(a) % 4;
      hit = (cmd != 0) && (m_st[ix] != I) && (m_addr[ix] == a);
      sh  = hit;
      fl  = hit && (m_st[ix] == M) && (cmd == 1 || cmd == 2);
      d   = fl ? m_data[ix] : 8'h00;
      if (hit) begin
         if (cmd == 1) m_st[ix] = S;
         else if (cmd == 2) m_st[ix] = I;
         else if (m_st[ix] == S) m_st[ix] = I;
      end
   endtask

   task automatic do_snoop(input int cmd, input logic [4:0] a);
      bit sh, fl;
      logic [7:0] d;
      model_snoop(cmd, a, sh, fl, d);
      @(negedge clk);
      snoop_valid = 1'b1; snoop_cmd = 2'(cmd); snoop_addr = a;
      @(negedge clk);
      snoop_valid = 1'b0;
      chk("snoop_shared", 32'(snoop_shared), 32'(sh));
      chk("snoop_flush", 32'(snoop_flush), 32'(fl));
      chk("snoop_data", 32'(snoop_data), 32'(d));
      $display("snoop cmd=%0d addr=0x%02h shared=%0b flush=%0b data=0x%02h",
               cmd, a, snoop_shared, snoop_flush, snoop_data);
      chk_lines("snoop");
   endtask

   // One CPU operation. snp_when: 0 no racing snoop, 1 snoop during LOOKUP,
   // 2 snoop in the first cycle bus_req is seen (before granting).
   task automatic cpu_op(input bit wr, input logic [4:0] a, input logic [7:0] wd,
                         input bit sh, input logic [7:0] md,
                         input int snp_when, input int snp_cmd, input logic [4:0] snp_a);
      int ix, exp_cmd, ncmd, nwb, lat, snp_chk_cyc;
      bit hit, exp_wb, got, saw_req, need_fill, snp_done;
      bit esh, efl;
      logic [7:0] ed, exp_rd, rd, wb_data_seen;
      logic [4:0] exp_wb_addr, wb_addr_seen, cmd_addr;
      logic [1:0] cmd_seen;

      esh = 0; efl = 0; ed = 8'h00;
      if (snp_when != 0) model_snoop(snp_cmd, snp_a, esh, efl, ed);
      ix          = int'(a) % 4;
      hit         = (m_st[ix] != I) && (m_addr[ix] == a);
      exp_wb      = !hit && (m_st[ix] == M);
      exp_wb_addr = m_addr[ix];
      wb_data_seen = 8'h00;
      ed          = efl ? ed : 8'h00;
      exp_rd      = hit ? m_data[ix] : md;
      if (hit) exp_cmd = (wr && m_st[ix] == S) ? 3 : 0;
      else     exp_cmd = wr ? 2 : 1;
      // reuse ed for flush data; capture victim data before model update
      wb_addr_seen = '0;
      begin
         logic [7:0] exp_wb_data;
         exp_wb_data = m_data[ix];
         if (hit) begin
            if (wr) begin m_data[ix] = wd; m_st[ix] = M; end
         end else begin
            m_addr[ix] = a;
            m_data[ix] = wr ? wd : md;
            m_st[ix]   = wr ? M : (sh ? S : E);
         end

         got = 0; saw_req = 0; need_fill = 0; snp_done = 0;
         ncmd = 0; nwb = 0; lat = 0; snp_chk_cyc = -1;
         rd = 8'h00; cmd_seen = 2'd0; cmd_addr = '0;

         @(negedge clk);
         chk("req_ready", 32'(cpu_req_ready), 1);
         cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_req_addr = a; cpu_req_wdata = wd;
         for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            cpu_req_valid = 1'b0; bus_gnt = 1'b0; bus_wb_ack = 1'b0;
            mem_rvalid = 1'b0; bus_shared_in = 1'b0; snoop_valid = 1'b0;
            if (cyc == snp_chk_cyc) begin
               chk("race_snoop_shared", 32'(snoop_shared), 32'(esh));
               chk("race_snoop_flush", 32'(snoop_flush), 32'(efl));
               chk("race_snoop_data", 32'(snoop_data), 32'(ed));
            end
            if (cpu_resp_valid) begin
               got = 1; lat = cyc; rd = cpu_resp_rdata;
               break;
            end
            if (bus_req) saw_req = 1;
            if (cyc == 1 && snp_when == 1) begin
               snoop_valid = 1'b1; snoop_cmd = 2'(snp_cmd); snoop_addr = snp_a;
               snp_chk_cyc = cyc + 1;
            end else if (need_fill) begin
               mem_rvalid = 1'b1; mem_rdata = md; bus_shared_in = sh;
               need_fill = 0;
            end else if (bus_wb_valid) begin
               nwb++;
               wb_addr_seen = bus_addr; wb_data_seen = bus_wb_data;
               bus_wb_ack = 1'b1;
            end else if (bus_req) begin
               if (snp_when == 2 && !snp_done) begin
                  snoop_valid = 1'b1; snoop_cmd = 2'(snp_cmd); snoop_addr = snp_a;
                  snp_done = 1; snp_chk_cyc = cyc + 1;
               end else if ($urandom_range(0, 3) != 0) begin
                  bus_gnt = 1'b1;
                  #1;
                  if (bus_cmd != 2'd0) begin
                     ncmd++; cmd_seen = bus_cmd; cmd_addr = bus_addr;
                     if (bus_cmd != 2'd3) need_fill = 1;
                  end
               end
            end
         end
         bus_gnt = 1'b0; bus_wb_ack = 1'b0; mem_rvalid = 1'b0;
         bus_shared_in = 1'b0; snoop_valid = 1'b0;

         $display("op %s addr=0x%02h wd=0x%02h resp=%0b rdata=0x%02h lat=%0d cmd=%0d wb=%0d",
                  wr ? "WR" : "RD", a, wd, got, rd, lat, cmd_seen, nwb);
         chk("resp_seen", 32'(got), 1);
         if (!wr) chk("rdata", 32'(rd), 32'(exp_rd));
         chk("bus_cmd_count", ncmd, (exp_cmd != 0) ? 1 : 0);
         if (exp_cmd != 0) begin
            chk("bus_cmd", 32'(cmd_seen), exp_cmd);
            chk("bus_cmd_addr", 32'(cmd_addr), 32'(a));
         end
         chk("wb_count", nwb, exp_wb ? 1 : 0);
         if (exp_wb) begin
            chk("wb_addr", 32'(wb_addr_seen), 32'(exp_wb_addr));
            chk("wb_data", 32'(wb_data_seen), 32'(exp_wb_data));
         end
         if (exp_cmd == 0 && snp_when == 0) begin
            chk("hit_latency", lat, 2);
            chk("hit_no_bus_req", 32'(saw_req), 0);
         end
         chk_lines("op");
      end
   endtask

   initial begin
      bit got_resp;
      model_reset();
      for (int i = 0; i < 4; i++) begin m_addr[i] = '0; m_data[i] = '0; end

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 32'(cpu_req_ready), 1);
      chk("rst_resp_valid", 32'(cpu_resp_valid), 0);
      chk("rst_bus_req", 32'(bus_req), 0);
      chk("rst_wb_valid", 32'(bus_wb_valid), 0);
      chk("rst_snoop_flush", 32'(snoop_flush), 0);
      chk_lines("rst");

      // Cold read -> E, then hit re-read
      cpu_op(0, 5'h05, 8'h00, 0, 8'hA1, 0, 0, 5'h00);
      cpu_op(0, 5'h05, 8'h00, 0, 8'hEE, 0, 0, 5'h00);
      // Silent E->M write, then BusRd snoop flushes and demotes to S
      cpu_op(1, 5'h05, 8'h3C, 0, 8'h00, 0, 0, 5'h00);
      do_snoop(1, 5'h05);
      // Write hit on S -> BusUpgr
      cpu_op(1, 5'h05, 8'h55, 0, 8'h00, 0, 0, 5'h00);
      // Shared fill -> S
      cpu_op(0, 5'h0A, 8'h00, 1, 8'h77, 0, 0, 5'h00);
      // Miss evicting dirty 0x05 -> write-back then BusRd
      cpu_op(0, 5'h0D, 8'h00, 0, 8'h42, 0, 0, 5'h00);
      // BusRdX snoop racing LOOKUP on the same index -> miss after the stall
      cpu_op(0, 5'h0D, 8'h00, 0, 8'h9B, 1, 2, 5'h0D);
      // BusRdX snoop while BusUpgr pending -> converted to BusRdX
      cpu_op(1, 5'h0A, 8'hC4, 0, 8'h11, 2, 2, 5'h0A);

      // Reset while waiting for fill data
      @(negedge clk);
      cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 5'h11; cpu_req_wdata = '0;
      got_resp = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         cpu_req_valid = 1'b0; bus_gnt = 1'b0;
         if (bus_req) begin
            bus_gnt = 1'b1;
            #1;
            got_resp = 1;
            break;
         end
      end
      chk("fill_rst_granted", 32'(got_resp), 1);
      @(negedge clk);
      bus_gnt = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("fill_rst_ready", 32'(cpu_req_ready), 1);
      chk("fill_rst_resp", 32'(cpu_resp_valid), 0);
      chk("fill_rst_bus_req", 32'(bus_req), 0);
      chk_lines("fill_rst");
      got_resp = 0;
      repeat (3) begin
         @(negedge clk);
         if (cpu_resp_valid) got_resp = 1;
      end
      chk("fill_rst_no_resp", 32'(got_resp), 0);
      $display("reset during fill: ready=%0b resp=%0b", cpu_req_ready, got_resp);

      // Randomized operations and snoops
      for (int n = 0; n < 80; n++) begin
         logic [4:0] ra, sa;
         ra = 5'(($urandom_range(0, 1) * 4) + $urandom_range(0, 3));
         sa = 5'(($urandom_range(0, 1) * 4) + $urandom_range(0, 3));
         if ($urandom_range(0, 9) < 7)
            cpu_op(1'($urandom_range(0, 1)), ra, 8'($urandom), 1'($urandom_range(0, 1)),
                   8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0,
                   $urandom_range(1, 3), sa);
         else
            do_snoop($urandom_range(1, 3), sa);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
